l1_ahb_mtx_slave_decoder: RTL
=============================

// Module: l1_ahb_mtx_slave_decoder
// PURPOSE
//  Output-side address decoder and response multiplexer for one master port of the L1 AHB matrix.
//  - Decodes the address phase into one-hot slave selects.
//  - Registers the data-phase owner and muxes HREADYOUT/HRESP/HRDATA back to the master.
//  - Sits directly upstream of the matrix default slave, which it instantiates and selects for unmapped addresses.
// PARAMETERS
//  NUM_SLV   4                     number of mapped slave ports (1..8)
//  SLV_BASE  {NUM_SLV{32'h0}}      packed 32-bit base per slave, slave i at [32*i+:32]
//  SLV_MASK  {NUM_SLV{32'hF0000000}} packed 32-bit compare mask per slave, same packing
// PORTS
//  HCLK       in   1          AHB clock; single clock domain, all flops on rising edge
//  HRESETn    in   1          asynchronous active-low reset
//  HSEL       in   1          master port routed to this decoder this address phase
//  HADDR      in   32         address-phase address
//  HTRANS     in   2          transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
//  HREADY     in   1          bus HREADY (transfer completes / address phase accepted)
//  HSELS      out  NUM_SLV    one-hot address-phase slave selects
//  HREADYOUTS in   NUM_SLV    per-slave HREADYOUT
//  HRESPS     in   2*NUM_SLV  per-slave HRESP, slave i at [2*i+:2]
//  HRDATAS    in   32*NUM_SLV per-slave HRDATA, slave i at [32*i+:32]
//  HREADYOUT  out  1          muxed ready to master
//  HRESP      out  2          muxed response to master
//  HRDATA     out  32         muxed read data to master
//  DPH_ACTIVE out  1          a data phase owned by this port is outstanding (for the arbiter)
// BEHAVIOUR
//  Address decode (combinational)
//  - match_i = ((HADDR & SLV_MASK_i) == SLV_BASE_i).
//  - Lowest matching index wins on overlap. A mask of 0 with base 0 is a catch-all.
//  - HSELS[i] = HSEL & match_i & no lower match. Not qualified by HTRANS; slaves qualify IDLE/BUSY themselves.
//  - def_sel = HSEL & ~|match; drives the HSEL input of the default slave.
//  Data-phase owner register dsel (NUM_SLV+2 states: NONE, SLV0..SLVn-1, DEF)
//  - HREADY=1 at a rising edge: dsel <= DEF if def_sel; SLVi if HSELS[i]; NONE if HSEL=0.
//  - HREADY=0: dsel holds. Wait states never move ownership.
//  - Reset (async): dsel=NONE.
//  Response mux (combinational from dsel)
//  - NONE: HREADYOUT=1, HRESP=00 (OKAY), HRDATA=32'h0.
//  - SLVi: HREADYOUT=HREADYOUTS[i], HRESP=HRESPS[2i+:2], HRDATA=HRDATAS[32i+:32].
//  - DEF: outputs of the default slave; HRDATA=32'h0.
//  - DPH_ACTIVE = (dsel != NONE).
//  Default slave contract
//  - NONSEQ/SEQ to an unmapped address gives a two-cycle ERROR: cycle1 HREADYOUT=0/HRESP=01, cycle2 HREADYOUT=1/HRESP=01.
//  - IDLE/BUSY to an unmapped address gives zero-wait OKAY.
//  Outputs after reset: HSELS=0 while HSEL=0; HREADYOUT=1, HRESP=00, HRDATA=0, DPH_ACTIVE=0.
//  Boundaries
//  - Back-to-back transfers to different slaves: dsel switches on the same edge the previous data phase completes.
//  - Address phase presented during a wait state: HSELS still driven; not registered until HREADY=1.
//  - Reset mid-transfer: dsel=NONE immediately (async); default slave returns to ready/OKAY.
//  - Latency: zero added cycles; address and data decode add no pipeline stage.
// STRUCTURE
//  Shared package l1_ahb_mtx_pkg:
//  - HTRANS codes (TRN_IDLE/BUSY/NONSEQ/SEQ)
//  - HRESP codes (RSP_OKAY 00, ERROR 01, RETRY 10, SPLIT 11)
//  - ADDR_W=32, DATA_W=32
//  Sub-module: one instance of cmsdk_L1AhbMtx_default_slave (HSEL=def_sel, HTRANS, HREADY).
//  - Decode and mux remain in this module as generate loops over NUM_SLV.
// TESTING (NUM_SLV=2; SLV0 base 0x00000000, SLV1 base 0x20000000, both mask 0xE0000000)
//  1 Reset: HRESETn=0 with HSEL=1, HADDR=0x20000004, HREADY=1.
//    -> HREADYOUT=1, HRESP=00, HRDATA=0, DPH_ACTIVE=0; HSELS=2'b10 combinationally.
//  2 NONSEQ read 0x20000010, HREADYOUTS[1] low 2 cycles, HRDATAS[1]=0xCAFEF00D.
//    -> HREADYOUT low 2 cycles, then 1 with HRDATA=0xCAFEF00D, HRESP=00.
//  3 NONSEQ to 0x40000000 (unmapped).
//    -> HSELS=00; data phase HREADYOUT 0 then 1, HRESP=01 both cycles; DPH_ACTIVE=1 across both.
//  4 IDLE to 0x40000000.
//    -> next cycle HREADYOUT=1, HRESP=00, no error.
//  5 Back-to-back NONSEQ 0x00000000 then 0x20000000, SLV0 inserts 1 wait.
//    -> dsel stays SLV0 through the wait, switches to SLV1 on completion edge; HRDATA follows owner.
//  6 Assert HRESETn=0 in cycle1 of a default-slave error.
//    -> immediately HREADYOUT=1, HRESP=00, DPH_ACTIVE=0; after release, a fresh NONSEQ decodes normally.

Source files
------------

// File: rtl/l1_ahb_mtx_pkg.sv
// Shared definitions for the L1 AHB matrix: bus widths and AHB transfer/response codes.
package l1_ahb_mtx_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        TRN_IDLE   = 2'b00,
        TRN_BUSY   = 2'b01,
        TRN_NONSEQ = 2'b10,
        TRN_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RSP_OKAY  = 2'b00,
        RSP_ERROR = 2'b01,
        RSP_RETRY = 2'b10,
        RSP_SPLIT = 2'b11
    } hresp_e;

endpackage

// File: rtl/l1_ahb_mtx_slave_decoder_default_slave.sv
// Matrix default slave: two-cycle ERROR for active transfers to unmapped space,
// zero-wait OKAY for IDLE/BUSY.
module cmsdk_L1AhbMtx_default_slave
    import l1_ahb_mtx_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    typedef enum logic [1:0] {DS_OKAY, DS_ERR1, DS_ERR2} ds_state_e;

    ds_state_e state, state_nxt;
    logic      trans_req;

    assign trans_req = HSEL & HREADY & ((HTRANS == TRN_NONSEQ) || (HTRANS == TRN_SEQ));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= DS_OKAY;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = RSP_OKAY;
        case (state)
            DS_OKAY: begin
                if (trans_req) state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RSP_ERROR;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP = RSP_ERROR;
                if (HREADY) state_nxt = trans_req ? DS_ERR1 : DS_OKAY;
            end
            default: state_nxt = DS_OKAY;
        endcase
    end

endmodule

// File: rtl/l1_ahb_mtx_slave_decoder.sv
// Address decoder and data-phase response mux for one master port of the L1 AHB matrix;
// unmapped addresses are routed to the embedded default slave.
module l1_ahb_mtx_slave_decoder
    import l1_ahb_mtx_pkg::*;
#(
    parameter int                      NUM_SLV  = 4,
    parameter logic [ADDR_W*NUM_SLV-1:0] SLV_BASE = {NUM_SLV{32'h0}},
    parameter logic [ADDR_W*NUM_SLV-1:0] SLV_MASK = {NUM_SLV{32'hF0000000}}
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        HSEL,
    input  logic [ADDR_W-1:0]           HADDR,
    input  logic [1:0]                  HTRANS,
    input  logic                        HREADY,
    output logic [NUM_SLV-1:0]          HSELS,
    input  logic [NUM_SLV-1:0]          HREADYOUTS,
    input  logic [2*NUM_SLV-1:0]        HRESPS,
    input  logic [DATA_W*NUM_SLV-1:0]   HRDATAS,
    output logic                        HREADYOUT,
    output logic [1:0]                  HRESP,
    output logic [DATA_W-1:0]           HRDATA,
    output logic                        DPH_ACTIVE
);

    logic [NUM_SLV-1:0] match;
    logic [NUM_SLV:0]   lower_hit;
    logic               def_sel;

    // Data-phase owner: all-zero means no outstanding data phase.
    logic [NUM_SLV-1:0] dsel_slv;
    logic               dsel_def;

    logic               def_readyout;
    logic [1:0]         def_resp;

    assign lower_hit[0] = 1'b0;

    // lower_hit[i] flags a match at any index below i, giving lowest-index priority.
    for (genvar i = 0; i < NUM_SLV; i++) begin : g_decode
        assign match[i]       = (HADDR & SLV_MASK[ADDR_W*i +: ADDR_W]) == SLV_BASE[ADDR_W*i +: ADDR_W];
        assign lower_hit[i+1] = lower_hit[i] | match[i];
        assign HSELS[i]       = HSEL & match[i] & ~lower_hit[i];
    end

    assign def_sel = HSEL & ~lower_hit[NUM_SLV];

    // Ownership only moves when the bus accepts the address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_slv <= '0;
            dsel_def <= 1'b0;
        end else if (HREADY) begin
            dsel_slv <= HSELS;
            dsel_def <= def_sel;
        end
    end

    cmsdk_L1AhbMtx_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (def_sel),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (def_readyout),
        .HRESP     (def_resp)
    );

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = RSP_OKAY;
        HRDATA    = '0;
        if (dsel_def) begin
            HREADYOUT = def_readyout;
            HRESP     = def_resp;
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel_slv[i]) begin
                HREADYOUT = HREADYOUTS[i];
                HRESP     = HRESPS[2*i +: 2];
                HRDATA    = HRDATAS[DATA_W*i +: DATA_W];
            end
        end
    end

    assign DPH_ACTIVE = dsel_def | (|dsel_slv);

endmodule
